// File: rtl/instr_fetch_unit.sv
// 16-bit little-endian instruction fetch from byte memory with req/ack reads and valid/ready handoff.
// Define FETCH_BRANCH_EN to add the PCLoad/PCIn branch-load ports.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  output logic [15:0] IROut,
  output logic        IRValid,
  input  logic        IRReady,
  output logic [15:0] PCOut,
  output logic        Busy,
  output logic        Timeout
`ifdef FETCH_BRANCH_EN
  ,
  input  logic        PCLoad,
  input  logic [15:0] PCIn
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_LO = 2'd1;
  localparam logic [1:0] REQ_HI = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int unsigned WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [1:0]    state;
  logic [15:0]   pc;
  logic [15:0]   instr_start;
  logic [WW-1:0] wait_cnt;
  logic          pc_load;
  logic [15:0]   pc_in;

`ifdef FETCH_BRANCH_EN
  assign pc_load = PCLoad;
  assign pc_in   = PCIn;
`else
  assign pc_load = 1'b0;
  assign pc_in   = '0;
`endif

  assign PCOut = pc;
  assign Busy  = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_start <= RESET_PC;
      MemAddr     <= RESET_PC;
      MemReq      <= 1'b0;
      IROut       <= '0;
      IRValid     <= 1'b0;
      Timeout     <= 1'b0;
      wait_cnt    <= '0;
    end else if (pc_load) begin
      // Branch load wins over any ack or handoff in the same cycle.
      state    <= IDLE;
      pc       <= pc_in;
      MemAddr  <= pc_in;
      MemReq   <= 1'b0;
      IRValid  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Enable && !Timeout) begin
            state       <= REQ_LO;
            MemReq      <= 1'b1;
            MemAddr     <= pc;
            instr_start <= pc;
            wait_cnt    <= '0;
          end
        end
        REQ_LO, REQ_HI: begin
          if (MemAck) begin
            wait_cnt <= '0;
            pc       <= pc + 16'd1;
            if (state == REQ_LO) begin
              IROut[7:0] <= MemData;
              MemAddr    <= pc + 16'd1;
              state      <= REQ_HI;
            end else begin
              IROut[15:8] <= MemData;
              MemReq      <= 1'b0;
              IRValid     <= 1'b1;
              state       <= HOLD;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort rewinds to the first byte of the instruction being fetched.
            Timeout  <= 1'b1;
            MemReq   <= 1'b0;
            pc       <= instr_start;
            MemAddr  <= instr_start;
            IRValid  <= 1'b0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (IRReady) begin
            IRValid <= 1'b0;
            if (Enable) begin
              state       <= REQ_LO;
              MemReq      <= 1'b1;
              MemAddr     <= pc;
              instr_start <= pc;
              wait_cnt    <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
